// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared widths, constants and FSM encoding for the MNIST frame feeder
package mnist_pkg;
   localparam int IMG_PIXELS_DEF = 784;
   localparam int PIX_W          = 8;
   localparam int CLASS_W        = 4;
   localparam logic [CLASS_W-1:0] RESULT_TIMEOUT = 4'hF;

   typedef enum logic [1:0] {
      ST_FILL     = 2'd0,
      ST_STREAM   = 2'd1,
      ST_WAIT_RES = 2'd2
   } feeder_state_e;
endpackage

// File: rtl/mnist_frame_feeder_if.sv
// rtl/mnist_frame_feeder_if.sv - feeder bus bundle; lat_cycles present only with FEEDER_LATENCY_CNT_EN
interface mnist_frame_feeder_if;
   import mnist_pkg::*;

   logic [PIX_W-1:0]   in_data;
   logic               in_valid;
   logic               in_ready;
   logic [PIX_W-1:0]   pix_data;
   logic               pix_valid;
   logic               core_valid;
   logic [CLASS_W-1:0] core_decision;
   logic [CLASS_W-1:0] result;
   logic               result_valid;
   logic               timeout_err;
   logic               busy;

`ifdef FEEDER_LATENCY_CNT_EN
   logic [15:0]        lat_cycles;

   modport master (
      input  in_data, in_valid, core_valid, core_decision,
      output in_ready, pix_data, pix_valid, result, result_valid, timeout_err, busy, lat_cycles
   );
   modport slave (
      output in_data, in_valid, core_valid, core_decision,
      input  in_ready, pix_data, pix_valid, result, result_valid, timeout_err, busy, lat_cycles
   );
`else
   modport master (
      input  in_data, in_valid, core_valid, core_decision,
      output in_ready, pix_data, pix_valid, result, result_valid, timeout_err, busy
   );
   modport slave (
      output in_data, in_valid, core_valid, core_decision,
      input  in_ready, pix_data, pix_valid, result, result_valid, timeout_err, busy
   );
`endif
endinterface

// File: rtl/mnist_frame_feeder_frame_buf.sv
// rtl/mnist_frame_feeder_frame_buf.sv - simple dual-port frame buffer with 1-cycle synchronous read
module frame_buf #(
   parameter int DEPTH = 784,
   parameter int WIDTH = 8,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   // write port: no reset so the array maps onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // registered read port
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/mnist_frame_feeder.sv
// rtl/mnist_frame_feeder.sv - buffers one frame, streams it to the CNN core, waits for its class (option: FEEDER_LATENCY_CNT_EN)
module mnist_frame_feeder
   import mnist_pkg::*;
#(
   parameter int IMG_PIXELS     = IMG_PIXELS_DEF,
   parameter int TIMEOUT_CYCLES = 6250
) (
   input logic                  clk,
   input logic                  rst,
   mnist_frame_feeder_if.master bus
);
   localparam int AW = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
   localparam int CW = $clog2(IMG_PIXELS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_FILL     = ST_FILL;
   localparam logic [1:0] S_STREAM   = ST_STREAM;
   localparam logic [1:0] S_WAIT_RES = ST_WAIT_RES;

   localparam logic [AW-1:0] LAST_ADDR   = AW'(IMG_PIXELS - 1);
   localparam logic [CW-1:0] FRAME_END   = CW'(IMG_PIXELS);
   localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT_CYCLES);

   logic [1:0]       state;
   logic [AW-1:0]    wr_cnt;
   logic [CW-1:0]    rd_cnt;
   logic [TW-1:0]    to_cnt;
   logic             pix_valid_r;
   logic [PIX_W-1:0] buf_q;
   logic             wr_en;
   logic             rd_en;
   logic             timed_out;

   assign bus.in_ready  = (state == S_FILL);
   assign wr_en         = bus.in_ready && bus.in_valid;
   // rd_cnt runs one past the frame so the state lingers until the last pixel is on the bus
   assign rd_en         = (state == S_STREAM) && (rd_cnt != FRAME_END);
   assign timed_out     = (to_cnt == TIMEOUT_END);
   assign bus.pix_valid = pix_valid_r;
   assign bus.pix_data  = pix_valid_r ? buf_q : '0;
   assign bus.busy      = (state != S_FILL);

   frame_buf #(
      .DEPTH (IMG_PIXELS),
      .WIDTH (PIX_W),
      .AW    (AW)
   ) u_frame_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_cnt),
      .wr_data (bus.in_data),
      .rd_en   (rd_en),
      .rd_addr (rd_cnt[AW-1:0]),
      .rd_data (buf_q)
   );

   // frame sequencing: fill the buffer, stream it out, then wait for the core's decision
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_FILL;
         wr_cnt           <= '0;
         rd_cnt           <= '0;
         to_cnt           <= '0;
         pix_valid_r      <= 1'b0;
         bus.result       <= '0;
         bus.result_valid <= 1'b0;
         bus.timeout_err  <= 1'b0;
      end else begin
         bus.result_valid <= 1'b0;
         bus.timeout_err  <= 1'b0;
         pix_valid_r      <= 1'b0;
         case (state)
            S_FILL: begin
               if (wr_en) begin
                  if (wr_cnt == LAST_ADDR) begin
                     wr_cnt <= '0;
                     state  <= S_STREAM;
                  end else begin
                     wr_cnt <= wr_cnt + AW'(1);
                  end
               end
            end
            S_STREAM: begin
               if (rd_en) begin
                  rd_cnt      <= rd_cnt + CW'(1);
                  pix_valid_r <= 1'b1;
               end else begin
                  rd_cnt <= '0;
                  to_cnt <= '0;
                  state  <= S_WAIT_RES;
               end
            end
            S_WAIT_RES: begin
               // a decision arriving on the timeout cycle still counts as a decision
               if (bus.core_valid) begin
                  bus.result       <= bus.core_decision;
                  bus.result_valid <= 1'b1;
                  state            <= S_FILL;
               end else if (timed_out) begin
                  bus.result       <= RESULT_TIMEOUT;
                  bus.result_valid <= 1'b1;
                  bus.timeout_err  <= 1'b1;
                  state            <= S_FILL;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

`ifdef FEEDER_LATENCY_CNT_EN
   logic [15:0] lat_run;

   // latency from first streamed pixel to the decision cycle, published alongside result_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_run        <= '0;
         bus.lat_cycles <= '0;
      end else if (state == S_FILL) begin
         lat_run <= '0;
      end else begin
         if ((pix_valid_r || state == S_WAIT_RES) && lat_run != 16'hFFFF)
            lat_run <= lat_run + 16'd1;
         if (state == S_WAIT_RES && (bus.core_valid || timed_out))
            bus.lat_cycles <= (lat_run == 16'hFFFF) ? lat_run : lat_run + 16'd1;
      end
   end
`endif
endmodule
